// File: rtl/pattern_serializer_if.sv
// Request/stream bundle for pattern_serializer: parallel pattern request in,
// serial w/w_valid stream and status out.
interface pattern_serializer_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned REP_W = 4
);
    logic [WIDTH-1:0] pat_data;
    logic [LEN_W-1:0] pat_len;
    logic [REP_W-1:0] pat_rep;
    logic             pat_valid;
    logic             pat_ready;
    logic             abort;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;

    modport master (
        output pat_data, pat_len, pat_rep, pat_valid, abort,
        input  pat_ready, w, w_valid, busy, done
    );

    modport slave (
        input  pat_data, pat_len, pat_rep, pat_valid, abort,
        output pat_ready, w, w_valid, busy, done
    );
endinterface

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: shifts a latched pattern out LSB-first on w/w_valid,
// repeating it with optional idle gaps. Define RUN_FLAG_EN to add the run4 output.
module pattern_serializer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned REP_W      = 4,
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic Clock,
    input  logic Resetn,
`ifdef RUN_FLAG_EN
    output logic run4,
`endif
    pattern_serializer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(WIDTH);
    localparam logic [3:0]       GapLast = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [LEN_W-1:0] len_last_q, len_last_d;
    logic [REP_W-1:0] rep_last_q, rep_last_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic             w_q, w_d;
    logic             w_valid_q, w_valid_d;
    logic             done_q, done_d;
    logic             accept, cancel;

    assign accept = (state_q == StIdle) && bus.pat_valid;
    assign cancel = (state_q != StIdle) && bus.abort;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        reload_d    = reload_q;
        len_last_d  = len_last_q;
        rep_last_d  = rep_last_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        w_d         = w_q;
        w_valid_d   = w_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d     = bus.pat_data >> 1;
                    reload_d    = bus.pat_data;
                    len_last_d  = (bus.pat_len == '0 || bus.pat_len > LenMax)
                                ? LenMax - LEN_W'(1) : bus.pat_len - LEN_W'(1);
                    rep_last_d  = (bus.pat_rep == '0) ? '0 : bus.pat_rep - REP_W'(1);
                    bit_cnt_d   = '0;
                    frame_cnt_d = '0;
                    w_d         = bus.pat_data[0];
                    w_valid_d   = 1'b1;
                    state_d     = StShift;
                end
            end
            StShift: begin
                if (cancel) begin
                    state_d   = StIdle;
                    w_d       = IDLE_LEVEL;
                    w_valid_d = 1'b0;
                end else if (bit_cnt_q == len_last_q) begin
                    if (frame_cnt_q == rep_last_q) begin
                        state_d   = StIdle;
                        w_d       = IDLE_LEVEL;
                        w_valid_d = 1'b0;
                        done_d    = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                        w_d       = IDLE_LEVEL;
                        w_valid_d = 1'b0;
                    end else begin
                        // Back-to-back frames: next frame's bit 0 with no bubble.
                        shift_d     = reload_q >> 1;
                        w_d         = reload_q[0];
                        bit_cnt_d   = '0;
                        frame_cnt_d = frame_cnt_q + REP_W'(1);
                    end
                end else begin
                    w_d       = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                end
            end
            StGap: begin
                if (cancel) begin
                    state_d   = StIdle;
                    w_d       = IDLE_LEVEL;
                    w_valid_d = 1'b0;
                end else if (gap_cnt_q == GapLast) begin
                    state_d     = StShift;
                    shift_d     = reload_q >> 1;
                    w_d         = reload_q[0];
                    w_valid_d   = 1'b1;
                    bit_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + REP_W'(1);
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            reload_q    <= '0;
            len_last_q  <= '0;
            rep_last_q  <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            gap_cnt_q   <= '0;
            w_q         <= IDLE_LEVEL;
            w_valid_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            reload_q    <= reload_d;
            len_last_q  <= len_last_d;
            rep_last_q  <= rep_last_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            w_q         <= w_d;
            w_valid_q   <= w_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.pat_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.w         = w_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.done      = done_q;

`ifdef RUN_FLAG_EN
    // Last three valid bits emitted for this request; gaps leave it untouched.
    logic [2:0] hist_q, hist_d;
    logic [1:0] hist_cnt_q, hist_cnt_d;

    always_comb begin
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        if (accept || cancel) begin
            hist_d     = '0;
            hist_cnt_d = '0;
        end else if (w_valid_q) begin
            hist_d = {hist_q[1:0], w_q};
            if (hist_cnt_q != 2'd3) begin
                hist_cnt_d = hist_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            hist_q     <= '0;
            hist_cnt_q <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
        end
    end

    assign run4 = w_valid_q && (hist_cnt_q == 2'd3) && (hist_q == {3{w_q}});
`endif

endmodule

// File: tb/tb_pattern_serializer.sv
// Randomized self-checking bench for pattern_serializer: two instances (no gap and
// two-cycle gap) compared cycle by cycle against a queue-based waveform model.
module tb_pattern_serializer;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned LEN_W = 5;
    localparam int unsigned REP_W = 4;
    localparam logic        IDLE_LEVEL = 1'b0;

    typedef struct packed {
        logic v;
        logic w;
        logic d;
        logic r;
        logic b;
        logic r4;
    } smp_t;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic run4_0, run4_2;
    int   n_checks = 0;
    int   n_pass = 0;
    smp_t exp_q[$];

    always #5 Clock = ~Clock;

    pattern_serializer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) bus0 ();
    pattern_serializer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) bus2 ();

    pattern_serializer #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYCLES(0), .IDLE_LEVEL(IDLE_LEVEL)
    ) u_dut0 (
        .Clock (Clock),
        .Resetn(Resetn),
`ifdef RUN_FLAG_EN
        .run4  (run4_0),
`endif
        .bus   (bus0)
    );

    pattern_serializer #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP_CYCLES(2), .IDLE_LEVEL(IDLE_LEVEL)
    ) u_dut2 (
        .Clock (Clock),
        .Resetn(Resetn),
`ifdef RUN_FLAG_EN
        .run4  (run4_2),
`endif
        .bus   (bus2)
    );

`ifndef RUN_FLAG_EN
    assign run4_0 = 1'b0;
    assign run4_2 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic smp_t mk(input logic v, w, d, r, b, r4);
        smp_t s;
        s.v = v; s.w = w; s.d = d; s.r = r; s.b = b; s.r4 = r4;
        return s;
    endfunction

    function automatic smp_t sample(input int sel);
        smp_t s;
        if (sel == 0) s = mk(bus0.w_valid, bus0.w, bus0.done, bus0.pat_ready, bus0.busy, run4_0);
        else          s = mk(bus2.w_valid, bus2.w, bus2.done, bus2.pat_ready, bus2.busy, run4_2);
        return s;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] d,
                         input logic [31:0] l, input logic [31:0] r, input logic a);
        if (sel == 0) begin
            bus0.pat_valid = v; bus0.pat_data = d[WIDTH-1:0];
            bus0.pat_len = l[LEN_W-1:0]; bus0.pat_rep = r[REP_W-1:0]; bus0.abort = a;
        end else begin
            bus2.pat_valid = v; bus2.pat_data = d[WIDTH-1:0];
            bus2.pat_len = l[LEN_W-1:0]; bus2.pat_rep = r[REP_W-1:0]; bus2.abort = a;
        end
    endtask

    // Expected per-cycle outputs from the cycle after acceptance to the done cycle.
    function automatic void build_model(input int gap, input logic [31:0] data,
                                        input int len, input int rep);
        int   le, re;
        logic b, r4;
        logic hist[$];
        le = (len == 0 || len > int'(WIDTH)) ? int'(WIDTH) : len;
        re = (rep == 0) ? 1 : rep;
        exp_q.delete();
        for (int f = 0; f < re; f++) begin
            for (int i = 0; i < le; i++) begin
                b  = data[i];
                r4 = (hist.size() >= 3) && (hist[hist.size()-1] == b) &&
                     (hist[hist.size()-2] == b) && (hist[hist.size()-3] == b);
                exp_q.push_back(mk(1'b1, b, 1'b0, 1'b0, 1'b1, r4));
                hist.push_back(b);
            end
            if (f < re - 1)
                for (int g = 0; g < gap; g++)
                    exp_q.push_back(mk(1'b0, IDLE_LEVEL, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        exp_q.push_back(mk(1'b0, IDLE_LEVEL, 1'b1, 1'b1, 1'b0, 1'b0));
    endfunction

    // Called at a negedge with the selected DUT idle; returns at the negedge of the
    // done (or post-abort) cycle with pat_valid dropped. abort_at<0 picks one at random.
    task automatic run_req(input string name, input int sel, input logic [31:0] data,
                           input int len, input int rep, input int abort_at_in,
                           input bit hold, input bit idle_abort);
        smp_t s, e;
        int   abort_at;
        build_model((sel == 0) ? 0 : 2, data, len, rep);
        abort_at = abort_at_in;
        if (abort_at < 0) abort_at = $urandom_range(1, exp_q.size() - 1);
        if (abort_at > 0 && abort_at < exp_q.size()) begin
            exp_q = exp_q[0:abort_at-1];
            exp_q.push_back(mk(1'b0, IDLE_LEVEL, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        drive(sel, 1'b1, data, len, rep, idle_abort);
        @(posedge Clock);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge Clock);
            s = sample(sel);
            e = exp_q[j];
            check($sformatf("%s[%0d].w_valid", name, j), 32'(s.v), 32'(e.v));
            check($sformatf("%s[%0d].w", name, j), 32'(s.w), 32'(e.w));
            check($sformatf("%s[%0d].done", name, j), 32'(s.d), 32'(e.d));
            check($sformatf("%s[%0d].pat_ready", name, j), 32'(s.r), 32'(e.r));
            check($sformatf("%s[%0d].busy", name, j), 32'(s.b), 32'(e.b));
`ifdef RUN_FLAG_EN
            check($sformatf("%s[%0d].run4", name, j), 32'(s.r4), 32'(e.r4));
`endif
            if (j == exp_q.size() - 1) drive(sel, 1'b0, '0, '0, '0, 1'b0);
            else drive(sel, hold, $urandom, $urandom, $urandom, (j + 1 == abort_at));
        end
    endtask

    initial begin
        smp_t s;
        drive(0, 1'b0, '0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge Clock);
        for (int sel = 0; sel < 2; sel++) begin
            s = sample(sel);
            check($sformatf("reset%0d.w_valid", sel), 32'(s.v), 32'd0);
            check($sformatf("reset%0d.w", sel), 32'(s.w), 32'(IDLE_LEVEL));
            check($sformatf("reset%0d.done", sel), 32'(s.d), 32'd0);
            check($sformatf("reset%0d.pat_ready", sel), 32'(s.r), 32'd1);
            check($sformatf("reset%0d.busy", sel), 32'(s.b), 32'd0);
        end
        Resetn = 1'b1;
        @(negedge Clock);

        run_req("t1", 0, 32'h00F0, 8, 1, 0, 1'b0, 1'b0);
        run_req("t2", 1, 32'h000A, 4, 3, 0, 1'b0, 1'b0);
        run_req("t3", 0, 32'hA5C3, 0, 0, 0, 1'b0, 1'b0);
        run_req("t4", 0, 32'h5A3C, 8, 1, 3, 1'b0, 1'b0);
        run_req("t6a", 0, 32'h1234, 6, 2, 0, 1'b1, 1'b0);
        run_req("t6b", 0, 32'hBEEF, 5, 1, 0, 1'b1, 1'b1);
        run_req("abort_last", 1, 32'h00FF, 4, 1, 4, 1'b0, 1'b0);
        run_req("abort_gap", 1, 32'h0F0F, 3, 2, 4, 1'b0, 1'b0);
        run_req("long", 0, 32'hFFFF, 31, 15, 0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int sel, len, rep, ab;
            sel = $urandom_range(0, 1);
            len = $urandom_range(0, 20);
            rep = (it % 10 == 0) ? 15 : $urandom_range(0, 4);
            ab  = ($urandom_range(0, 3) == 0) ? -1 : 0;
            run_req($sformatf("rnd%0d", it), sel, $urandom, len, rep, ab,
                    1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        end

        // Asynchronous reset in the middle of a frame of ones.
        drive(0, 1'b1, 32'hFFFF, 16, 1, 1'b0);
        @(posedge Clock);
        @(negedge Clock);
        drive(0, 1'b0, '0, '0, '0, 1'b0);
        s = sample(0);
        check("t5.pre_w_valid", 32'(s.v), 32'd1);
        check("t5.pre_w", 32'(s.w), 32'd1);
        @(posedge Clock);
        #2 Resetn = 1'b0;
        #1 s = sample(0);
        check("t5.w_valid", 32'(s.v), 32'd0);
        check("t5.w", 32'(s.w), 32'(IDLE_LEVEL));
        check("t5.pat_ready", 32'(s.r), 32'd1);
        check("t5.busy", 32'(s.b), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        run_req("recover", 0, 32'h0C3A, 12, 2, 0, 1'b0, 1'b0);
        @(negedge Clock);
        s = sample(0);
        check("done_one_cycle", 32'(s.d), 32'd0);
        check("idle_w_valid", 32'(s.v), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
